// File: rtl/instr_byte_fetcher.sv
// Sequential Y86-64 instruction byte gatherer: reads 1/2/9/10 bytes from a byte-wide memory
// and presents the 80-bit instruction window with valP, length and status flags.
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// ISSUE | one byte read per cycle; byte k-1 is captured while byte k issues
// DRAIN | capture the last in-flight byte (if any)
// DONE  | result held on out_* until out_ready
module instr_byte_fetcher #(
  parameter int unsigned MEM_SIZE = 65536,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [63:0]       req_pc,
  output logic              req_ready,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [79:0]       out_instr,
  output logic [63:0]       out_valp,
  output logic [3:0]        out_len,
  output logic              out_mem_error,
  output logic              out_instr_inv
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [64:0] MEM_LIMIT = 65'(MEM_SIZE);

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [3:0]  k_q, k_d;
  logic [3:0]  len_q, len_d;
  logic [79:0] instr_q, instr_d;
  logic [63:0] valp_q, valp_d;
  logic        err_q, err_d;
  logic        inv_q, inv_d;
  logic        dcap_q, dcap_d;

  logic [64:0] byte_addr;
  logic        in_range;
  logic [3:0]  len_cur;
  logic [3:0]  cap_idx;
  logic        cap_en;
  logic        rd_c;

  function automatic logic [3:0] len_of(input logic [3:0] icode);
    logic [3:0] l;
    case (icode)
      4'h2, 4'h6, 4'hA, 4'hB: l = 4'd2;
      4'h7, 4'h8:             l = 4'd9;
      4'h3, 4'h4, 4'h5:       l = 4'd10;
      default:                l = 4'd1;
    endcase
    return l;
  endfunction

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    k_d     = k_q;
    len_d   = len_q;
    instr_d = instr_q;
    valp_d  = valp_q;
    err_d   = err_q;
    inv_d   = inv_q;
    dcap_d  = dcap_q;
    rd_c    = 1'b0;
    cap_en  = 1'b0;
    cap_idx = k_q - 4'd1;

    // 65-bit sum so a PC near 2**64 cannot wrap back into range
    byte_addr = {1'b0, pc_q} + {61'b0, k_q};
    in_range  = (byte_addr < MEM_LIMIT);
    len_cur   = (k_q == 4'd1) ? len_of(mem_rdata[7:4]) : len_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          pc_d    = req_pc;
          k_d     = 4'd0;
          len_d   = 4'd0;
          instr_d = '0;
          valp_d  = '0;
          err_d   = 1'b0;
          inv_d   = 1'b0;
          dcap_d  = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cap_en = (k_q != 4'd0);
        if (k_q == 4'd1) begin
          len_d = len_cur;
          inv_d = (mem_rdata[7:4] >= 4'hC);
        end
        if (k_q != 4'd0 && k_q >= len_cur) begin
          // single-byte instruction: byte 0 lands now, nothing more to read
          state_d = S_DONE;
        end else if (!in_range) begin
          err_d = 1'b1;
          if (k_q == 4'd0) begin
            len_d   = 4'd1;
            state_d = S_DONE;
          end else begin
            dcap_d  = 1'b0;
            state_d = S_DRAIN;
          end
        end else begin
          rd_c = 1'b1;
          k_d  = k_q + 4'd1;
          if (k_q != 4'd0 && k_q == len_cur - 4'd1) begin
            dcap_d  = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        cap_en  = dcap_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (cap_en) begin
      for (int i = 0; i < 10; i++) begin
        if (cap_idx == 4'(i)) instr_d[79-8*i -: 8] = mem_rdata;
      end
    end

    if (state_d == S_DONE && state_q != S_DONE) valp_d = pc_q + {60'b0, len_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      k_q     <= '0;
      len_q   <= '0;
      instr_q <= '0;
      valp_q  <= '0;
      err_q   <= 1'b0;
      inv_q   <= 1'b0;
      dcap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      k_q     <= k_d;
      len_q   <= len_d;
      instr_q <= instr_d;
      valp_q  <= valp_d;
      err_q   <= err_d;
      inv_q   <= inv_d;
      dcap_q  <= dcap_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign out_valid     = (state_q == S_DONE);
  assign mem_rd        = rd_c;
  assign mem_addr      = rd_c ? byte_addr[ADDR_W-1:0] : '0;
  assign out_instr     = instr_q;
  assign out_valp      = valp_q;
  assign out_len       = len_q;
  assign out_mem_error = err_q;
  assign out_instr_inv = inv_q;

endmodule

// File: tb/tb_instr_byte_fetcher.sv
// Directed bench for instr_byte_fetcher: Y86 program at 64..103, MEM_SIZE=104 so the
// top of the program doubles as the memory-range boundary.
module tb_instr_byte_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [63:0] req_pc;
  logic        req_ready;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [79:0] out_instr;
  logic [63:0] out_valp;
  logic [3:0]  out_len;
  logic        out_mem_error;
  logic        out_instr_inv;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mem [0:255];
  logic [15:0] rd_log[$];

  instr_byte_fetcher #(.MEM_SIZE(104), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_valp(out_valp), .out_len(out_len),
    .out_mem_error(out_mem_error), .out_instr_inv(out_instr_inv)
  );

  always #5 clk = ~clk;

  // memory answers one cycle after the strobe; 0xEE otherwise so stray captures show up
  always @(posedge clk) begin
    if (mem_rd === 1'b1 && mem_addr < 16'd256) mem_rdata <= mem[mem_addr[7:0]];
    else mem_rdata <= 8'hEE;
  end

  always @(negedge clk) begin
    if (mem_rd === 1'b1) rd_log.push_back(mem_addr);
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [63:0] pc, input logic [79:0] e_instr, input logic [3:0] e_len,
                       input logic [63:0] e_valp, input logic e_err, input logic e_inv,
                       input int e_lat, input int e_nrd, input int hold);
    int  lat;
    bit  done;
    @(negedge clk);
    chk("req_ready_idle", {79'b0, req_ready}, 80'd1);
    rd_log.delete();
    req_valid = 1'b1;
    req_pc    = pc;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat  = 0;
    done = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1) done = 1;
    end
    chk("out_valid_timeout", {79'b0, done}, 80'd1);
    if (e_lat > 0) chk("latency", 80'(lat), 80'(e_lat));
    chk("out_instr", out_instr, e_instr);
    chk("out_len", {76'b0, out_len}, {76'b0, e_len});
    chk("out_valp", {16'b0, out_valp}, {16'b0, e_valp});
    chk("out_mem_error", {79'b0, out_mem_error}, {79'b0, e_err});
    chk("out_instr_inv", {79'b0, out_instr_inv}, {79'b0, e_inv});
    chk("read_count", 80'(rd_log.size()), 80'(e_nrd));
    for (int i = 0; i < rd_log.size() && i < e_nrd; i++)
      chk("read_addr", {64'b0, rd_log[i]}, {64'b0, pc[15:0] + 16'(i)});
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      chk("hold_valid", {79'b0, out_valid}, 80'd1);
      chk("hold_req_ready", {79'b0, req_ready}, 80'd0);
      chk("hold_instr", out_instr, e_instr);
      chk("hold_valp", {16'b0, out_valp}, {16'b0, e_valp});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] prog [0:39];
    prog = '{8'h20, 8'h12,
             8'h30, 8'hF3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1F,
             8'h40, 8'h13, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h50, 8'h23, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h60, 8'h31, 8'hA1, 8'h2F, 8'hB0, 8'h3F, 8'h10, 8'h00};
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    for (int a = 0; a < 40; a++) mem[64 + a] = prog[a];
    mem[50] = 8'hC0;

    reset = 1'b1; req_valid = 1'b0; req_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {79'b0, req_ready}, 80'd1);
    chk("rst_mem_rd", {79'b0, mem_rd}, 80'd0);
    chk("rst_mem_addr", {64'b0, mem_addr}, 80'd0);
    chk("rst_out_valid", {79'b0, out_valid}, 80'd0);
    chk("rst_out_instr", out_instr, 80'd0);
    chk("rst_out_valp", {16'b0, out_valp}, 80'd0);
    chk("rst_out_len", {76'b0, out_len}, 80'd0);
    chk("rst_flags", {78'b0, out_mem_error, out_instr_inv}, 80'd0);

    // nop and irmovq
    fetch(64'd102, 80'h10000000000000000000, 4'd1, 64'd103, 1'b0, 1'b0, 3, 1, 0);
    fetch(64'd66, 80'h30F3000000000000001F, 4'd10, 64'd76, 1'b0, 1'b0, 12, 10, 0);
    // pushq with consumer back-pressure
    fetch(64'd98, 80'hA12F0000000000000000, 4'd2, 64'd100, 1'b0, 1'b0, 4, 2, 5);

    // stream through the whole program
    fetch(64'd64, 80'h20120000000000000000, 4'd2, 64'd66, 1'b0, 1'b0, 4, 2, 0);
    fetch(64'd66, 80'h30F3000000000000001F, 4'd10, 64'd76, 1'b0, 1'b0, 12, 10, 0);
    fetch(64'd76, 80'h40130800000000000000, 4'd10, 64'd86, 1'b0, 1'b0, 12, 10, 0);
    fetch(64'd86, 80'h50231000000000000000, 4'd10, 64'd96, 1'b0, 1'b0, 12, 10, 0);
    fetch(64'd96, 80'h60310000000000000000, 4'd2, 64'd98, 1'b0, 1'b0, 4, 2, 0);
    fetch(64'd98, 80'hA12F0000000000000000, 4'd2, 64'd100, 1'b0, 1'b0, 4, 2, 0);
    fetch(64'd100, 80'hB03F0000000000000000, 4'd2, 64'd102, 1'b0, 1'b0, 4, 2, 0);
    fetch(64'd102, 80'h10000000000000000000, 4'd1, 64'd103, 1'b0, 1'b0, 3, 1, 0);
    fetch(64'd103, 80'h00000000000000000000, 4'd1, 64'd104, 1'b0, 1'b0, 3, 1, 0);

    // invalid icode
    fetch(64'd50, 80'hC0000000000000000000, 4'd1, 64'd51, 1'b0, 1'b1, 3, 1, 0);

    // range errors: at k=2, at k=1, at k=0, and k=0 with valP wrap
    mem[102] = 8'h30;
    fetch(64'd102, 80'h30000000000000000000, 4'd10, 64'd112, 1'b1, 1'b0, 0, 2, 0);
    mem[102] = 8'h10;
    mem[103] = 8'h60;
    fetch(64'd103, 80'h60000000000000000000, 4'd2, 64'd105, 1'b1, 1'b0, 0, 1, 0);
    mem[103] = 8'h00;
    fetch(64'd200, 80'h0, 4'd1, 64'd201, 1'b1, 1'b0, 0, 0, 0);
    fetch(64'hFFFF_FFFF_FFFF_FFFF, 80'h0, 4'd1, 64'd0, 1'b1, 1'b0, 0, 0, 0);

    // reset during irmovq, asserted in cycle 4
    @(negedge clk);
    req_valid = 1'b1; req_pc = 64'd66;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_req_ready", {79'b0, req_ready}, 80'd1);
    chk("mid_rst_mem_rd", {79'b0, mem_rd}, 80'd0);
    chk("mid_rst_out_valid", {79'b0, out_valid}, 80'd0);
    chk("mid_rst_out_instr", out_instr, 80'd0);
    chk("mid_rst_out_len", {76'b0, out_len}, 80'd0);
    fetch(64'd102, 80'h10000000000000000000, 4'd1, 64'd103, 1'b0, 1'b0, 3, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
